alu_result_fifo: RTL and testbench
==================================

Name: alu_result_fifo

Overview:
- Downstream stage of the pipelined ALU; captures every valid result/flag triple the ALU emits.
- The ALU has no backpressure, so this block is the elastic buffer between it and a ready/valid consumer.
- Provides first-word-fall-through output plus an early stall signal sized for the ALU's in-flight stages.

Parameters:
- WIDTH, `WORD (shared define), result data width.
- DEPTH, 8, entry count; power of two, >= 4.
- SLACK, 2, entries reserved for ALU in-flight results; must satisfy 1 <= SLACK < DEPTH.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_result  in  WIDTH  ALU result.
- i_zero  in  1  ALU zero flag.
- i_cf  in  1  ALU carry flag.
- i_valid  in  1  result/flags valid this cycle.
- o_stall  out  1  upstream must stop issuing new ALU ops.
- o_data  out  WIDTH  head entry result.
- o_zero  out  1  head entry zero flag.
- o_cf  out  1  head entry carry flag.
- o_valid  out  1  head entry valid (FIFO not empty).
- i_ready  in  1  consumer accepts head entry.
- o_count  out  $clog2(DEPTH)+1  current occupancy.
- o_overflow  out  1  sticky; a valid input was dropped.
- i_clr_stats  in  1  synchronous clear of o_overflow and the statistics counters.
- o_zero_cnt  out  16  popped entries with zero flag set.
- o_cf_cnt  out  16  popped entries with carry flag set.

Behaviour:
- Storage: DEPTH entries of {cf, zero, result}, WIDTH+2 bits each.
- Pointers are $clog2(DEPTH)+1 bits with a wrap bit.
  - empty when the pointers are equal.
  - full when the index bits are equal and the wrap bits differ.
- Reset (i_rst_n low, asynchronous): pointers, o_count, o_overflow and both counters go to 0.
  - o_valid=0 and o_stall=0.
  - Memory contents are not reset; o_data/o_zero/o_cf are don't-care while o_valid=0.
- Pop occurs when o_valid && i_ready. The read pointer advances on the clock edge.
- Push occurs when i_valid && (!full || pop). The entry is written at the write pointer, which then advances.
- Full with a simultaneous pop: push is accepted and o_count is unchanged.
- Drop occurs when i_valid && full && !pop.
  - The entry is discarded and o_overflow is set on the next edge.
  - o_overflow stays set until i_clr_stats or reset.
- Output path:
  - o_valid = !empty. o_data/o_zero/o_cf are a combinational read of the head entry.
  - A push into an empty FIFO is visible on the cycle after the push edge (1-cycle latency).
- o_count: increments on push only, decrements on pop only, unchanged on both or neither.
- o_stall: combinational from registered state; o_stall = (o_count >= DEPTH-SLACK).
- i_ready while o_valid=0 has no effect; the pointers hold.
- Wrap-around: pointers wrap modulo 2*DEPTH. Ordering is strictly FIFO across wrap.
- i_clr_stats:
  - Clears o_overflow and both counters on the next edge.
  - Takes priority over a same-cycle increment or set.
  - Does not affect FIFO contents.
- Reset mid-operation discards all buffered entries immediately.

Optional Feature:
- Macro: ALU_RESULT_FIFO_STATS_EN.
- Defined:
  - o_zero_cnt increments on each pop whose head zero flag is 1.
  - o_cf_cnt increments on each pop whose head carry flag is 1.
  - Both counters saturate at 16'hFFFF and do not wrap.
- Undefined:
  - Counter registers are not built; o_zero_cnt and o_cf_cnt are tied to 0.
  - The port list is unchanged.
- o_overflow is unaffected by the macro.

Decomposition:
- Shared package/defines file:
  - `WORD.
  - An entry-width constant (`WORD+2).
  - Bit-position constants for the cf and zero fields within an entry.
- One natural sub-module: alu_result_fifo_mem, a DEPTH x (WIDTH+2) register array with a synchronous write port and a combinational read port.
- Pointer, count and statistics logic stay in the top block.

Test Plan:
- Reset then idle → o_valid=0, o_count=0, o_stall=0, o_overflow=0.
  - Assert i_rst_n low mid-traffic with 3 entries held → o_count=0 and o_valid=0 asynchronously.
- Push 0x5A/z0/c1 with i_ready=0 → next cycle o_valid=1, o_data=0x5A, o_cf=1, o_count=1.
  - Then i_ready=1 for one cycle → o_valid=0, o_count=0.
- DEPTH=8, SLACK=2, i_ready=0, push 1..6 → o_stall=1 once o_count=6.
  - Push 7..8 → full, o_overflow=0.
  - Push 9 → dropped, o_overflow=1, o_count=8.
  - Drain → outputs 1..8 in order.
- Full FIFO with i_valid=1 and i_ready=1 in the same cycle → push accepted, o_count stays 8, o_overflow stays 0.
- Continuous push/pop of 20 values, 0x00..0x13 → output sequence identical across pointer wrap; o_count never exceeds 1 when pop follows each push.
- STATS_EN defined: pop 5 entries with zero flags 1,0,1,1,0 and cf flags 0,1,1,0,0 → o_zero_cnt=3, o_cf_cnt=2.
  - Then pulse i_clr_stats → both counters 0.
  - Undefined build → both counters read 0 throughout.

Source files
------------

// File: rtl/alu_result_fifo_pkg.sv
// Shared constants for the ALU result FIFO: the `WORD data width and the
// layout of one stored entry {cf, zero, result}.
`ifndef WORD
`define WORD 8
`endif

package alu_result_fifo_pkg;
    localparam int ENTRY_W        = `WORD + 2;
    localparam int ENTRY_ZERO_BIT = `WORD;
    localparam int ENTRY_CF_BIT   = `WORD + 1;
endpackage

// File: rtl/alu_result_fifo_mem.sv
// Entry storage for the ALU result FIFO: synchronous write port and a
// combinational read port so the head entry falls straight through.
import alu_result_fifo_pkg::*;

module alu_result_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int EW    = ENTRY_W
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [EW-1:0]            i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [EW-1:0]            o_rdata
);

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (i_we) begin
            mem_d[i_waddr] = i_wdata;
        end
    end

    // Contents are deliberately not reset; the head is only meaningful while the FIFO is non-empty.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// Elastic first-word-fall-through buffer behind the pipelined ALU, with early stall,
// sticky overflow and optional pop statistics (ALU_RESULT_FIFO_STATS_EN).
import alu_result_fifo_pkg::*;

module alu_result_fifo #(
    parameter int WIDTH = `WORD,
    parameter int DEPTH = 8,
    parameter int SLACK = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [WIDTH-1:0]         i_result,
    input  logic                     i_zero,
    input  logic                     i_cf,
    input  logic                     i_valid,
    output logic                     o_stall,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_zero,
    output logic                     o_cf,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    input  logic                     i_clr_stats,
    output logic [15:0]              o_zero_cnt,
    output logic [15:0]              o_cf_cnt
);

    localparam int IW       = $clog2(DEPTH);
    localparam int PW       = IW + 1;
    localparam int EW       = WIDTH + (ENTRY_W - `WORD);
    localparam int ZERO_POS = WIDTH + (ENTRY_ZERO_BIT - `WORD);
    localparam int CF_POS   = WIDTH + (ENTRY_CF_BIT - `WORD);
    localparam logic [PW-1:0] STALL_LEVEL = PW'(DEPTH - SLACK);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          empty, full, push, pop, drop;
    logic [EW-1:0] wr_entry, rd_entry;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
    assign pop   = !empty && i_ready;
    // A pop frees the slot this edge, so a full FIFO can still take the ALU result.
    assign push  = i_valid && (!full || pop);
    assign drop  = i_valid && full && !pop;

    always_comb begin
        wr_entry                = '0;
        wr_entry[WIDTH-1:0]     = i_result;
        wr_entry[ZERO_POS]      = i_zero;
        wr_entry[CF_POS]        = i_cf;
    end

    alu_result_fifo_mem #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (push),
        .i_waddr (wr_ptr_q[IW-1:0]),
        .i_wdata (wr_entry),
        .i_raddr (rd_ptr_q[IW-1:0]),
        .o_rdata (rd_entry)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{IW{1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{IW{1'b0}}, pop};
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = i_clr_stats ? 1'b0 : (overflow_q || drop);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_valid    = !empty;
    assign o_data     = rd_entry[WIDTH-1:0];
    assign o_zero     = rd_entry[ZERO_POS];
    assign o_cf       = rd_entry[CF_POS];
    assign o_count    = count_q;
    assign o_overflow = overflow_q;
    assign o_stall    = (count_q >= STALL_LEVEL);

`ifdef ALU_RESULT_FIFO_STATS_EN
    logic [15:0] zero_cnt_q, zero_cnt_d;
    logic [15:0] cf_cnt_q, cf_cnt_d;

    // Counters saturate rather than wrap so a long run never reads as a small count.
    always_comb begin
        zero_cnt_d = zero_cnt_q;
        cf_cnt_d   = cf_cnt_q;
        if (i_clr_stats) begin
            zero_cnt_d = '0;
            cf_cnt_d   = '0;
        end else if (pop) begin
            if (o_zero && (zero_cnt_q != 16'hFFFF)) begin
                zero_cnt_d = zero_cnt_q + 16'd1;
            end
            if (o_cf && (cf_cnt_q != 16'hFFFF)) begin
                cf_cnt_d = cf_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            zero_cnt_q <= '0;
            cf_cnt_q   <= '0;
        end else begin
            zero_cnt_q <= zero_cnt_d;
            cf_cnt_q   <= cf_cnt_d;
        end
    end

    assign o_zero_cnt = zero_cnt_q;
    assign o_cf_cnt   = cf_cnt_q;
`else
    assign o_zero_cnt = '0;
    assign o_cf_cnt   = '0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed scoreboard bench for alu_result_fifo; expected counters follow
// whether ALU_RESULT_FIFO_STATS_EN is defined for the build.
module tb_alu_result_fifo;

   localparam int DEPTH = 8;
   localparam int SLACK = 2;

   logic        i_clk;
   logic        i_rst_n;
   logic [7:0]  i_result;
   logic        i_zero;
   logic        i_cf;
   logic        i_valid;
   logic        o_stall;
   logic [7:0]  o_data;
   logic        o_zero;
   logic        o_cf;
   logic        o_valid;
   logic        i_ready;
   logic [3:0]  o_count;
   logic        o_overflow;
   logic        i_clr_stats;
   logic [15:0] o_zero_cnt;
   logic [15:0] o_cf_cnt;

   int vectors = 0;
   int miscompares = 0;

   // Scoreboard entries are {cf, zero, data} in push order.
   logic [9:0] sb[$];
   logic       expOvf;
   int         expZeroCnt;
   int         expCfCnt;

   alu_result_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH),
      .SLACK (SLACK)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_result    (i_result),
      .i_zero      (i_zero),
      .i_cf        (i_cf),
      .i_valid     (i_valid),
      .o_stall     (o_stall),
      .o_data      (o_data),
      .o_zero      (o_zero),
      .o_cf        (o_cf),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_count     (o_count),
      .o_overflow  (o_overflow),
      .i_clr_stats (i_clr_stats),
      .o_zero_cnt  (o_zero_cnt),
      .o_cf_cnt    (o_cf_cnt)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Every comparison funnels through here so the tallies stay consistent.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs, checks the head against the scoreboard before the
   // edge, then checks registered state after the edge.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic z, input logic c,
                                input logic rdy, input logic clr);
      int         pre;
      logic       popping;
      logic [9:0] head;
      i_valid     = v;
      i_result    = d;
      i_zero      = z;
      i_cf        = c;
      i_ready     = rdy;
      i_clr_stats = clr;
      #1;
      pre = sb.size();
      checkOutput("o_valid", {31'd0, o_valid}, {31'd0, pre != 0});
      popping = rdy && (pre != 0);
      if (popping) begin
         head = sb.pop_front();
         checkOutput("o_data", {24'd0, o_data}, {24'd0, head[7:0]});
         checkOutput("o_zero", {31'd0, o_zero}, {31'd0, head[8]});
         checkOutput("o_cf", {31'd0, o_cf}, {31'd0, head[9]});
`ifdef ALU_RESULT_FIFO_STATS_EN
         if (head[8] && expZeroCnt < 65535) expZeroCnt++;
         if (head[9] && expCfCnt < 65535) expCfCnt++;
`endif
      end
      if (v) begin
         if (pre < DEPTH || popping) sb.push_back({c, z, d});
         else expOvf = 1'b1;
      end
      if (clr) begin
         expOvf     = 1'b0;
         expZeroCnt = 0;
         expCfCnt   = 0;
      end
      @(posedge i_clk);
      #1;
      checkOutput("o_count", {28'd0, o_count}, sb.size());
      checkOutput("o_overflow", {31'd0, o_overflow}, {31'd0, expOvf});
      checkOutput("o_stall", {31'd0, o_stall}, {31'd0, sb.size() >= DEPTH - SLACK});
      checkOutput("o_zero_cnt", {16'd0, o_zero_cnt}, expZeroCnt);
      checkOutput("o_cf_cnt", {16'd0, o_cf_cnt}, expCfCnt);
   endtask

   initial begin
      logic [4:0] zPat;
      logic [4:0] cPat;
      zPat = 5'b01101;
      cPat = 5'b00110;
      expOvf      = 1'b0;
      expZeroCnt  = 0;
      expCfCnt    = 0;
      i_rst_n     = 1'b0;
      i_valid     = 1'b0;
      i_result    = 8'h00;
      i_zero      = 1'b0;
      i_cf        = 1'b0;
      i_ready     = 1'b0;
      i_clr_stats = 1'b0;

      // Reset and idle.
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      #1;
      checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
      checkOutput("rst_count", {28'd0, o_count}, 32'd0);
      checkOutput("rst_stall", {31'd0, o_stall}, 32'd0);
      checkOutput("rst_overflow", {31'd0, o_overflow}, 32'd0);
      @(posedge i_clk);
      #1;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Single entry, one-cycle fall-through latency, then pop.
      applyStimulus(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("ftw_valid", {31'd0, o_valid}, 32'd1);
      checkOutput("ftw_data", {24'd0, o_data}, 32'h5A);
      checkOutput("ftw_cf", {31'd0, o_cf}, 32'd1);
      checkOutput("ftw_count", {28'd0, o_count}, 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("pop_valid", {31'd0, o_valid}, 32'd0);
      checkOutput("pop_count", {28'd0, o_count}, 32'd0);

      // Ready while empty must not disturb the pointers.
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

      // Fill to the stall threshold, then full, then overflow.
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
         if (i == 5) checkOutput("stall_at5", {31'd0, o_stall}, 32'd0);
      end
      checkOutput("stall_at6", {31'd0, o_stall}, 32'd1);
      applyStimulus(1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("full_overflow", {31'd0, o_overflow}, 32'd0);
      checkOutput("full_count", {28'd0, o_count}, 32'd8);
      applyStimulus(1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("drop_overflow", {31'd0, o_overflow}, 32'd1);
      checkOutput("drop_count", {28'd0, o_count}, 32'd8);
      for (int i = 1; i <= 8; i++) begin
         i_ready = 1'b1;
         #1;
         checkOutput("drain_order", {24'd0, o_data}, i);
         #(-1 + 1);
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      end

      // Clear sticky overflow, refill, then push and pop together while full.
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("clr_overflow", {31'd0, o_overflow}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 8'h40 + 8'(i), i[0], i[1], 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("fullpp_count", {28'd0, o_count}, 32'd8);
      checkOutput("fullpp_overflow", {31'd0, o_overflow}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      end

      // Streaming across pointer wrap.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 8'(i), (i == 0), i[0], 1'b1, 1'b0);
         checkOutput("wrap_count_le1", {31'd0, o_count <= 4'd1}, 32'd1);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

      // Flag statistics over five pops, then clear.
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'h60 + 8'(i), zPat[i], cPat[i], 1'b0, 1'b0);
      end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      end
`ifdef ALU_RESULT_FIFO_STATS_EN
      checkOutput("stats_zero", {16'd0, o_zero_cnt}, 32'd3);
      checkOutput("stats_cf", {16'd0, o_cf_cnt}, 32'd2);
`else
      checkOutput("stats_zero_off", {16'd0, o_zero_cnt}, 32'd0);
      checkOutput("stats_cf_off", {16'd0, o_cf_cnt}, 32'd0);
`endif
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("clr_zero_cnt", {16'd0, o_zero_cnt}, 32'd0);
      checkOutput("clr_cf_cnt", {16'd0, o_cf_cnt}, 32'd0);

      // Asynchronous reset with three entries buffered.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      end
      i_valid = 1'b0;
      i_ready = 1'b0;
      #2;
      i_rst_n = 1'b0;
      #1;
      checkOutput("async_rst_count", {28'd0, o_count}, 32'd0);
      checkOutput("async_rst_valid", {31'd0, o_valid}, 32'd0);
      sb.delete();
      expOvf     = 1'b0;
      expZeroCnt = 0;
      expCfCnt   = 0;
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
